// File: rtl/friet_c_lwc_dout_serializer.sv
// FRIET-C LWC output serializer: turns one cipher block into G_WIDTH-bit
// words, most significant word first, and raises dout_last on the final
// word of a message. Sits directly in front of the LWC output buffer.
//
// Optional feature macro: FRIET_C_LWC_DOUT_SERIALIZER_ZERO_PAD_EN
//   defined   -> bytes at index >= din_size are zeroed in every emitted word
//   undefined -> emitted words carry the raw latched block bytes
module friet_c_lwc_dout_serializer #(
  parameter int G_WIDTH       = 32,
  parameter int G_BLOCK_WIDTH = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [G_BLOCK_WIDTH-1:0]          din,
  input  logic [$clog2(G_BLOCK_WIDTH/8):0]  din_size,
  input  logic                              din_last,
  input  logic                              din_valid,
  output logic                              din_ready,
  output logic [G_WIDTH-1:0]                dout,
  output logic                              dout_last,
  output logic                              dout_valid,
  input  logic                              dout_ready
);

  localparam int NW  = G_BLOCK_WIDTH / G_WIDTH;
  localparam int BPW = G_WIDTH / 8;
  localparam int NB  = G_BLOCK_WIDTH / 8;
  localparam int CW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int SW  = $clog2(NB) + 1;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [CW-1:0]            cnt_q;
  logic [CW-1:0]            last_idx_q;
  logic [CW-1:0]            last_idx_d;
  logic [G_BLOCK_WIDTH-1:0] block_q;
  logic [G_BLOCK_WIDTH-1:0] din_load;
  logic                     last_q;
  logic [SW-1:0]            size_c;
  logic                     word_final;
  logic                     load;
  logic                     advance;
  logic                     clear;

  // An oversized din_size is clamped to a full block.
  assign size_c = (din_size > SW'(NB)) ? SW'(NB) : din_size;

  // Index of the last word to emit: ceil(size/BPW) - 1.
  assign last_idx_d = CW'((size_c - SW'(1)) / SW'(BPW));

  assign word_final = (cnt_q == last_idx_q);

`ifdef FRIET_C_LWC_DOUT_SERIALIZER_ZERO_PAD_EN
  // Zero the bytes beyond din_size before they are stored, so every word
  // that later leaves the shift register is already masked.
  always_comb begin
    din_load = din;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(size_c)) begin
        din_load[G_BLOCK_WIDTH-1-8*i -: 8] = 8'h00;
      end
    end
  end
`else
  assign din_load = din;
`endif

  // Next-state and handshake decode; a final-word handshake may reload a
  // new block in the same cycle so consecutive blocks leave with no bubble.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    advance    = 1'b0;
    clear      = 1'b0;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        din_ready = 1'b1;
        if (din_valid && (size_c != '0)) begin
          load    = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        dout_valid = 1'b1;
        din_ready  = dout_ready && word_final;
        if (dout_ready) begin
          if (word_final) begin
            if (din_valid && (size_c != '0)) begin
              load = 1'b1;
            end else begin
              clear   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      din_ready = 1'b0;
    end
  end

  // Output word is the top of the shift register, forced to zero when idle.
  always_comb begin
    dout      = '0;
    dout_last = 1'b0;
    if (state_q == S_SEND) begin
      dout      = block_q[G_BLOCK_WIDTH-1 -: G_WIDTH];
      dout_last = last_q && word_final;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Block storage shifts one word up per handshake; the counter tracks
  // which word is on dout so the last word of the block can be found.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_q    <= '0;
      last_q     <= 1'b0;
      last_idx_q <= '0;
      cnt_q      <= '0;
    end else if (load) begin
      block_q    <= din_load;
      last_q     <= din_last;
      last_idx_q <= last_idx_d;
      cnt_q      <= '0;
    end else if (advance) begin
      block_q    <= block_q << G_WIDTH;
      cnt_q      <= cnt_q + CW'(1);
    end else if (clear) begin
      cnt_q      <= '0;
    end
  end

endmodule

// File: tb/tb_friet_c_lwc_dout_serializer.sv
// Directed self-checking bench for friet_c_lwc_dout_serializer
// (default 32-bit words, 128-bit blocks).
module tb_friet_c_lwc_dout_serializer;

  logic         clk;
  logic         rst;
  logic [127:0] din;
  logic [4:0]   din_size;
  logic         din_last;
  logic         din_valid;
  logic         din_ready;
  logic [31:0]  dout;
  logic         dout_last;
  logic         dout_valid;
  logic         dout_ready;

  int checks = 0;
  int errors = 0;

  logic [127:0] blkA;
  logic [127:0] blkB;
  logic [31:0]  wordsA [4];
  logic [31:0]  wordsB [4];
  logic [31:0]  partialWord;

  friet_c_lwc_dout_serializer #(
    .G_WIDTH       (32),
    .G_BLOCK_WIDTH (128)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_size   (din_size),
    .din_last   (din_last),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all block-side and downstream-ready inputs at once.
  task automatic applyStimulus(input logic [127:0] d, input logic [4:0] size,
                               input logic last, input logic valid,
                               input logic ready);
    din        = d;
    din_size   = size;
    din_last   = last;
    din_valid  = valid;
    dout_ready = ready;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int cyc;
    logic rdy;

    blkA = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    blkB = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
    wordsA[0] = 32'h00112233; wordsA[1] = 32'h44556677;
    wordsA[2] = 32'h8899AABB; wordsA[3] = 32'hCCDDEEFF;
    wordsB[0] = 32'hA0A1A2A3; wordsB[1] = 32'hB0B1B2B3;
    wordsB[2] = 32'hC0C1C2C3; wordsB[3] = 32'hD0D1D2D3;
`ifdef FRIET_C_LWC_DOUT_SERIALIZER_ZERO_PAD_EN
    partialWord = 32'h44550000;
`else
    partialWord = 32'h44556677;
`endif

    // Reset state
    rst = 1'b1;
    applyStimulus('0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_dout", dout, 32'd0);
    checkOutput("rst_dout_last", 32'(dout_last), 32'd0);
    checkOutput("rst_din_ready", 32'(din_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_din_ready", 32'(din_ready), 32'd1);

    // Full block, four consecutive words, last only on the fourth
    applyStimulus(blkA, 5'd16, 1'b1, 1'b1, 1'b1);
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("full_valid%0d", k), 32'(dout_valid), 32'd1);
      checkOutput($sformatf("full_word%0d", k), dout, wordsA[k]);
      checkOutput($sformatf("full_last%0d", k), 32'(dout_last), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    checkOutput("full_idle_valid", 32'(dout_valid), 32'd0);
    checkOutput("full_idle_dout", dout, 32'd0);

    // Partial block of 6 bytes -> two words
    applyStimulus(blkA, 5'd6, 1'b1, 1'b1, 1'b1);
    tick();
    din_valid = 1'b0;
    checkOutput("part_word0", dout, 32'h00112233);
    checkOutput("part_last0", 32'(dout_last), 32'd0);
    tick();
    checkOutput("part_word1", dout, partialWord);
    checkOutput("part_last1", 32'(dout_last), 32'd1);
    tick();
    checkOutput("part_idle_valid", 32'(dout_valid), 32'd0);

    // Back-to-back blocks, din_valid held, no bubble
    applyStimulus(blkA, 5'd16, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(blkB, 5'd16, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("b2b_valid%0d", k), 32'(dout_valid), 32'd1);
      checkOutput($sformatf("b2b_word%0d", k), dout, (k < 4) ? wordsA[k] : wordsB[k-4]);
      checkOutput($sformatf("b2b_last%0d", k), 32'(dout_last), (k == 7) ? 32'd1 : 32'd0);
      if (k < 4) begin
        checkOutput($sformatf("b2b_din_ready%0d", k), 32'(din_ready), (k == 3) ? 32'd1 : 32'd0);
      end
      tick();
      if (k == 3) din_valid = 1'b0;
    end
    checkOutput("b2b_idle_valid", 32'(dout_valid), 32'd0);

    // Stalls: dout_ready pattern 1,0,0 repeating
    applyStimulus(blkA, 5'd16, 1'b1, 1'b1, 1'b1);
    tick();
    din_valid = 1'b0;
    w = 0;
    cyc = 0;
    while (w < 4 && cyc < 20) begin
      rdy = ((cyc % 3) == 0);
      dout_ready = rdy;
      #1;
      checkOutput($sformatf("stall_valid%0d", cyc), 32'(dout_valid), 32'd1);
      checkOutput($sformatf("stall_word%0d", cyc), dout, wordsA[w]);
      checkOutput($sformatf("stall_last%0d", cyc), 32'(dout_last), (w == 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("stall_din_ready%0d", cyc), 32'(din_ready),
                  (rdy && w == 3) ? 32'd1 : 32'd0);
      tick();
      if (rdy) w++;
      cyc++;
    end
    checkOutput("stall_all_words", 32'(w), 32'd4);
    checkOutput("stall_idle_valid", 32'(dout_valid), 32'd0);

    // Empty block consumed silently, then single-word block
    applyStimulus(blkA, 5'd0, 1'b1, 1'b1, 1'b1);
    tick();
    din_valid = 1'b0;
    checkOutput("empty_valid", 32'(dout_valid), 32'd0);
    checkOutput("empty_din_ready", 32'(din_ready), 32'd1);
    applyStimulus(blkA, 5'd4, 1'b1, 1'b1, 1'b1);
    tick();
    din_valid = 1'b0;
    checkOutput("single_word", dout, 32'h00112233);
    checkOutput("single_last", 32'(dout_last), 32'd1);
    tick();
    checkOutput("single_idle_valid", 32'(dout_valid), 32'd0);

    // Oversized din_size is clamped to a full block
    applyStimulus(blkB, 5'd20, 1'b1, 1'b1, 1'b1);
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("clamp_word3", dout, 32'hD0D1D2D3);
    checkOutput("clamp_last3", 32'(dout_last), 32'd1);
    tick();
    checkOutput("clamp_idle_valid", 32'(dout_valid), 32'd0);

    // Reset in the middle of a block discards the remaining words
    applyStimulus(blkA, 5'd16, 1'b1, 1'b1, 1'b1);
    tick();
    din_valid = 1'b0;
    tick();
    checkOutput("mid_word1", dout, 32'h44556677);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(dout_valid), 32'd0);
    checkOutput("midrst_din_ready", 32'(din_ready), 32'd0);
    checkOutput("midrst_dout", dout, 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("postrst_valid%0d", k), 32'(dout_valid), 32'd0);
    end
    checkOutput("postrst_din_ready", 32'(din_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
